// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control FSM. One memory port is shared between instruction fetch and data access.
// A sticky fault is raised on an illegal opcode or when memory stays busy for too long.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic       o_pcWrite,
    output logic       o_irWrite,
    output logic       o_iorD,
    output logic       o_memRead,
    output logic       o_memWrite,
    output logic       o_byteEn,
    output logic       o_regWrite,
    output logic       o_regDst,
    output logic       o_memToReg,
    output logic       o_linkWrite,
    output logic       o_ALUsrcA,
    output logic [1:0] o_ALUsrcB,
    output logic [2:0] o_ALUop,
    output logic [1:0] o_pcSource,
    output logic       o_instrDone,
    output logic       o_fault,
    output logic [2:0] o_state
);
    // ALU operation codes shared with the datapath ALU decoder
    localparam logic [2:0] ALUOP_AND   = 3'b000;
    localparam logic [2:0] ALUOP_OR    = 3'b001;
    localparam logic [2:0] ALUOP_ADD   = 3'b010;
    localparam logic [2:0] ALUOP_RTYPE = 3'b011;
    localparam logic [2:0] ALUOP_SUB   = 3'b110;
    localparam logic [2:0] ALUOP_LESS  = 3'b111;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd2;
    localparam logic [5:0] OP_SUBI = 6'd3;
    localparam logic [5:0] OP_ANDI = 6'd4;
    localparam logic [5:0] OP_ORI  = 6'd5;
    localparam logic [5:0] OP_SLTI = 6'd7;
    localparam logic [5:0] OP_LW   = 6'd8;
    localparam logic [5:0] OP_LB   = 6'd9;
    localparam logic [5:0] OP_SW   = 6'd10;
    localparam logic [5:0] OP_SB   = 6'd11;
    localparam logic [5:0] OP_MOVE = 6'd20;
    localparam logic [5:0] OP_BEQ  = 6'd23;
    localparam logic [5:0] OP_BNE  = 6'd27;
    localparam logic [5:0] OP_J    = 6'd38;
    localparam logic [5:0] OP_JAL  = 6'd39;

    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [5:0]      r_opReg;
    logic [CW-1:0]   r_waitCnt;

    logic w_isLoad, w_isStore, w_isByte, w_isMem, w_memWait, w_timeout;

    assign w_isLoad  = (r_opReg == OP_LW) || (r_opReg == OP_LB);
    assign w_isStore = (r_opReg == OP_SW) || (r_opReg == OP_SB);
    assign w_isByte  = (r_opReg == OP_LB) || (r_opReg == OP_SB);
    assign w_isMem   = w_isLoad || w_isStore;
    assign w_memWait = ((r_state == S_FETCH) || (r_state == S_MEM)) && !i_memReady;
    assign w_timeout = w_memWait && (r_waitCnt == WAIT_LIMIT);

    // The wait counter only survives while the FSM sits in the same memory state with memReady low
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_FETCH;
            r_opReg   <= '0;
            r_waitCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_DECODE)
                r_opReg <= i_opcode;
            if (w_memWait && (w_nextState == r_state))
                r_waitCnt <= r_waitCnt + CW'(1);
            else
                r_waitCnt <= '0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        o_pcWrite   = 1'b0;
        o_irWrite   = 1'b0;
        o_iorD      = 1'b0;
        o_memRead   = 1'b0;
        o_memWrite  = 1'b0;
        o_byteEn    = 1'b0;
        o_regWrite  = 1'b0;
        o_regDst    = 1'b0;
        o_memToReg  = 1'b0;
        o_linkWrite = 1'b0;
        o_ALUsrcA   = 1'b0;
        o_ALUsrcB   = 2'b00;
        o_ALUop     = ALUOP_AND;
        o_pcSource  = 2'b00;
        o_instrDone = 1'b0;
        o_fault     = (r_state == S_FAULT);
        o_state     = r_state;

        case (r_state)
            S_FETCH: begin
                o_memRead = 1'b1;
                o_ALUsrcB = 2'b01;
                o_ALUop   = ALUOP_ADD;
                if (i_memReady) begin
                    o_irWrite   = 1'b1;
                    o_pcWrite   = 1'b1;
                    w_nextState = S_DECODE;
                end else if (w_timeout) begin
                    w_nextState = S_FAULT;
                end
            end
            S_DECODE: begin
                o_ALUsrcB = 2'b11;
                o_ALUop   = ALUOP_ADD;
                case (i_opcode)
                    OP_R, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI,
                    OP_LW, OP_LB, OP_SW, OP_SB:  w_nextState = S_EXEC;
                    OP_BEQ, OP_BNE:              w_nextState = S_BRANCH;
                    OP_J, OP_JAL:                w_nextState = S_JUMP;
                    OP_MOVE:                     w_nextState = S_WB;
                    default:                     w_nextState = S_FAULT;
                endcase
            end
            S_EXEC: begin
                o_ALUsrcA = 1'b1;
                o_ALUsrcB = 2'b10;
                case (r_opReg)
                    OP_R: begin
                        o_ALUsrcB = 2'b00;
                        o_ALUop   = ALUOP_RTYPE;
                    end
                    OP_SUBI: o_ALUop = ALUOP_SUB;
                    OP_ANDI: o_ALUop = ALUOP_AND;
                    OP_ORI:  o_ALUop = ALUOP_OR;
                    OP_SLTI: o_ALUop = ALUOP_LESS;
                    default: o_ALUop = ALUOP_ADD;
                endcase
                w_nextState = w_isMem ? S_MEM : S_WB;
            end
            S_MEM: begin
                o_iorD     = 1'b1;
                o_memRead  = w_isLoad;
                o_memWrite = w_isStore;
                o_byteEn   = w_isByte;
                if (i_memReady) begin
                    o_instrDone = w_isStore;
                    w_nextState = w_isLoad ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_nextState = S_FAULT;
                end
            end
            S_WB: begin
                o_regWrite  = 1'b1;
                o_regDst    = (r_opReg == OP_R);
                o_memToReg  = w_isLoad;
                o_instrDone = 1'b1;
                w_nextState = S_FETCH;
            end
            S_BRANCH: begin
                o_ALUsrcA   = 1'b1;
                o_ALUop     = ALUOP_SUB;
                o_pcSource  = 2'b01;
                o_pcWrite   = ((r_opReg == OP_BEQ) && i_zero) || ((r_opReg == OP_BNE) && !i_zero);
                o_instrDone = 1'b1;
                w_nextState = S_FETCH;
            end
            S_JUMP: begin
                o_pcWrite   = 1'b1;
                o_pcSource  = 2'b10;
                o_regWrite  = (r_opReg == OP_JAL);
                o_linkWrite = (r_opReg == OP_JAL);
                o_instrDone = 1'b1;
                w_nextState = S_FETCH;
            end
            S_FAULT: w_nextState = S_FAULT;
        endcase

        // Reset silences every output, so an aborted instruction never leaks a strobe
        if (i_rst) begin
            o_pcWrite   = 1'b0;
            o_irWrite   = 1'b0;
            o_iorD      = 1'b0;
            o_memRead   = 1'b0;
            o_memWrite  = 1'b0;
            o_byteEn    = 1'b0;
            o_regWrite  = 1'b0;
            o_regDst    = 1'b0;
            o_memToReg  = 1'b0;
            o_linkWrite = 1'b0;
            o_ALUsrcA   = 1'b0;
            o_ALUsrcB   = 2'b00;
            o_ALUop     = ALUOP_AND;
            o_pcSource  = 2'b00;
            o_instrDone = 1'b0;
            o_fault     = 1'b0;
            o_state     = 3'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: each driven cycle queues its hand-derived expected
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_multicycle_sequencer;
    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010;
    localparam logic [2:0] A_RT  = 3'b011, A_SUB = 3'b110, A_LESS = 3'b111;
    localparam logic [5:0] OPX   = 6'h3F;

    typedef struct packed {
        logic [2:0] state;
        logic       fault, instrDone, pcWrite, irWrite, iorD, memRead, memWrite, byteEn;
        logic       regWrite, regDst, memToReg, linkWrite, aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
    } outs_t;

    typedef struct {
        string name;
        outs_t exp;
    } item_t;

    logic clk = 1'b0;
    logic rst, zero, memReady;
    logic [5:0] opcode;
    logic pcWrite, irWrite, iorD, memRead, memWrite, byteEn, regWrite, regDst, memToReg;
    logic linkWrite, ALUsrcA, instrDone, fault;
    logic [1:0] ALUsrcB, pcSource;
    logic [2:0] ALUop, state;
    outs_t act;
    item_t q[$];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_zero(zero), .i_memReady(memReady),
        .o_pcWrite(pcWrite), .o_irWrite(irWrite), .o_iorD(iorD), .o_memRead(memRead),
        .o_memWrite(memWrite), .o_byteEn(byteEn), .o_regWrite(regWrite), .o_regDst(regDst),
        .o_memToReg(memToReg), .o_linkWrite(linkWrite), .o_ALUsrcA(ALUsrcA), .o_ALUsrcB(ALUsrcB),
        .o_ALUop(ALUop), .o_pcSource(pcSource), .o_instrDone(instrDone), .o_fault(fault),
        .o_state(state)
    );

    always_comb begin
        act = '{state, fault, instrDone, pcWrite, irWrite, iorD, memRead, memWrite, byteEn,
                regWrite, regDst, memToReg, linkWrite, ALUsrcA, ALUsrcB, ALUop, pcSource};
    end

    // Monitor: one expected record is consumed per cycle, mid-cycle while inputs are stable
    always @(negedge clk) begin
        item_t it;
        if (q.size() > 0) begin
            it = q.pop_front();
            compared++;
            if (act !== it.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h required %h", it.name, act, it.exp);
            end
        end
    end

    function automatic outs_t fetchExp(input logic rdy);
        outs_t e = '0;
        e.memRead = 1'b1; e.aluSrcB = 2'b01; e.aluOp = A_ADD;
        e.irWrite = rdy;  e.pcWrite = rdy;
        return e;
    endfunction

    function automatic outs_t decodeExp();
        outs_t e = '0;
        e.state = 3'd1; e.aluSrcB = 2'b11; e.aluOp = A_ADD;
        return e;
    endfunction

    function automatic outs_t execExp(input logic [1:0] srcB, input logic [2:0] op);
        outs_t e = '0;
        e.state = 3'd2; e.aluSrcA = 1'b1; e.aluSrcB = srcB; e.aluOp = op;
        return e;
    endfunction

    function automatic outs_t memExp(input logic load, input logic isByte, input logic rdy);
        outs_t e = '0;
        e.state = 3'd3; e.iorD = 1'b1; e.memRead = load; e.memWrite = !load;
        e.byteEn = isByte; e.instrDone = rdy && !load;
        return e;
    endfunction

    function automatic outs_t wbExp(input logic rd, input logic m2r);
        outs_t e = '0;
        e.state = 3'd4; e.regWrite = 1'b1; e.regDst = rd; e.memToReg = m2r; e.instrDone = 1'b1;
        return e;
    endfunction

    function automatic outs_t branchExp(input logic pcw);
        outs_t e = '0;
        e.state = 3'd5; e.aluSrcA = 1'b1; e.aluOp = A_SUB; e.pcSource = 2'b01;
        e.pcWrite = pcw; e.instrDone = 1'b1;
        return e;
    endfunction

    function automatic outs_t jumpExp(input logic jal);
        outs_t e = '0;
        e.state = 3'd6; e.pcWrite = 1'b1; e.pcSource = 2'b10;
        e.regWrite = jal; e.linkWrite = jal; e.instrDone = 1'b1;
        return e;
    endfunction

    function automatic outs_t faultExp();
        outs_t e = '0;
        e.state = 3'd7; e.fault = 1'b1;
        return e;
    endfunction

    task automatic applyStimulus(input string name, input logic r, input logic [5:0] op,
                                 input logic z, input logic rdy, input outs_t exp);
        item_t it;
        rst = r; opcode = op; zero = z; memReady = rdy;
        it.name = name;
        it.exp  = exp;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic [5:0] op, input logic z,
                        input logic rdy, input outs_t exp);
        applyStimulus(name, 1'b0, op, z, rdy, exp);
    endtask

    task automatic fetchDecode(input string name, input logic [5:0] op);
        step({name, " fetch"}, OPX, 1'b0, 1'b1, fetchExp(1'b1));
        step({name, " decode"}, op, 1'b0, 1'b1, decodeExp());
    endtask

    task automatic checkOutput();
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending required 0", q.size());
        end
    endtask

    initial begin
        logic [5:0] immOps [3] = '{6'd3, 6'd5, 6'd7};
        logic [2:0] immAlu [3] = '{A_SUB, A_OR, A_LESS};
        rst = 1'b1; opcode = OPX; zero = 1'b0; memReady = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("reset0", 1'b1, OPX, 1'b0, 1'b1, '0);
        applyStimulus("reset1", 1'b1, OPX, 1'b0, 1'b1, '0);

        fetchDecode("addi", 6'd2);
        step("addi exec", OPX, 1'b0, 1'b1, execExp(2'b10, A_ADD));
        step("addi wb", OPX, 1'b0, 1'b1, wbExp(1'b0, 1'b0));

        fetchDecode("lw", 6'd8);
        step("lw exec", OPX, 1'b0, 1'b1, execExp(2'b10, A_ADD));
        for (int i = 0; i < 3; i++) step("lw mem wait", OPX, 1'b0, 1'b0, memExp(1'b1, 1'b0, 1'b0));
        step("lw mem ready", OPX, 1'b0, 1'b1, memExp(1'b1, 1'b0, 1'b1));
        step("lw wb", OPX, 1'b0, 1'b1, wbExp(1'b0, 1'b1));

        fetchDecode("rtype", 6'd0);
        step("rtype exec", OPX, 1'b0, 1'b1, execExp(2'b00, A_RT));
        step("rtype wb", OPX, 1'b0, 1'b1, wbExp(1'b1, 1'b0));

        for (int i = 0; i < 3; i++) begin
            fetchDecode("imm", immOps[i]);
            step("imm exec", OPX, 1'b0, 1'b1, execExp(2'b10, immAlu[i]));
            step("imm wb", OPX, 1'b0, 1'b1, wbExp(1'b0, 1'b0));
        end

        fetchDecode("sb", 6'd11);
        step("sb exec", OPX, 1'b0, 1'b1, execExp(2'b10, A_ADD));
        step("sb mem", OPX, 1'b0, 1'b1, memExp(1'b0, 1'b1, 1'b1));

        fetchDecode("beq z1", 6'd23);
        step("beq z1 branch", OPX, 1'b1, 1'b1, branchExp(1'b1));
        fetchDecode("bne z1", 6'd27);
        step("bne z1 branch", OPX, 1'b1, 1'b1, branchExp(1'b0));
        fetchDecode("bne z0", 6'd27);
        step("bne z0 branch", OPX, 1'b0, 1'b1, branchExp(1'b1));
        fetchDecode("beq z0", 6'd23);
        step("beq z0 branch", OPX, 1'b0, 1'b1, branchExp(1'b0));

        fetchDecode("jal", 6'd39);
        step("jal jump", OPX, 1'b0, 1'b1, jumpExp(1'b1));
        fetchDecode("j", 6'd38);
        step("j jump", OPX, 1'b0, 1'b1, jumpExp(1'b0));
        fetchDecode("move", 6'd20);
        step("move wb", OPX, 1'b0, 1'b1, wbExp(1'b0, 1'b0));

        fetchDecode("illegal", 6'b110000);
        for (int i = 0; i < 10; i++) step("illegal fault", OPX, 1'b0, 1'b1, faultExp());
        applyStimulus("illegal rst", 1'b1, OPX, 1'b0, 1'b1, '0);

        for (int i = 0; i < 16; i++) step("fetch wait", OPX, 1'b0, 1'b0, fetchExp(1'b0));
        step("fetch timeout", OPX, 1'b0, 1'b0, faultExp());
        applyStimulus("timeout rst", 1'b1, OPX, 1'b0, 1'b0, '0);
        for (int i = 0; i < 15; i++) step("fetch wait2", OPX, 1'b0, 1'b0, fetchExp(1'b0));
        step("fetch late ready", OPX, 1'b0, 1'b1, fetchExp(1'b1));
        step("late decode", 6'd38, 1'b0, 1'b1, decodeExp());
        step("late jump", OPX, 1'b0, 1'b1, jumpExp(1'b0));

        fetchDecode("lb", 6'd9);
        step("lb exec", OPX, 1'b0, 1'b1, execExp(2'b10, A_ADD));
        for (int i = 0; i < 16; i++) step("lb mem wait", OPX, 1'b0, 1'b0, memExp(1'b1, 1'b1, 1'b0));
        step("lb mem timeout", OPX, 1'b0, 1'b0, faultExp());
        applyStimulus("lb rst", 1'b1, OPX, 1'b0, 1'b0, '0);

        fetchDecode("sw", 6'd10);
        step("sw exec", OPX, 1'b0, 1'b1, execExp(2'b10, A_ADD));
        step("sw mem wait", OPX, 1'b0, 1'b0, memExp(1'b0, 1'b0, 1'b0));
        applyStimulus("sw rst in mem", 1'b1, OPX, 1'b0, 1'b1, '0);
        step("after rst fetch", OPX, 1'b0, 1'b0, fetchExp(1'b0));
        fetchDecode("final j", 6'd38);
        step("final jump", OPX, 1'b0, 1'b1, jumpExp(1'b0));

        checkOutput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
